// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared types and helpers for the programmable sequence detector.
//   seqdet_len_w() - width of a length field able to hold 0..max_len
//   seqdet_mode_e  - overlap / non-overlap detection mode
//   seqdet_cfg_t   - config record at the default pattern width
package seqdet_pkg;

  localparam int unsigned SEQDET_MAX_LEN = 8;

  function automatic int unsigned seqdet_len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int unsigned SEQDET_LEN_W = seqdet_len_w(SEQDET_MAX_LEN);

  typedef enum logic {
    SEQ_NONOVL = 1'b0,
    SEQ_OVL    = 1'b1
  } seqdet_mode_e;

  typedef struct packed {
    logic [SEQDET_MAX_LEN-1:0] pattern;
    logic [SEQDET_LEN_W-1:0]   len;
    seqdet_mode_e              mode;
  } seqdet_cfg_t;

endpackage

// File: rtl/seqdet_prog_if.sv
// seqdet_prog_if: serial stream, configuration and detect signals of seqdet_prog.
//   i_valid/i_data        serial bit and its qualifier
//   cfg_load/cfg_*        runtime configuration strobe and values
//   o_det                 registered detect pulse
//   o_det_cnt             saturating detect count (only with SEQDET_CNT_EN)
// master: stream/config source; slave: the detector.
interface seqdet_prog_if
  import seqdet_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8
`ifdef SEQDET_CNT_EN
  ,
  parameter int unsigned CNT_W   = 8
`endif
);

  localparam int unsigned LEN_W = seqdet_len_w(MAX_LEN);

  logic               i_valid;
  logic               i_data;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               o_det;
`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0]   o_det_cnt;

  modport master (
    output i_valid, i_data, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  o_det, o_det_cnt
  );
  modport slave (
    input  i_valid, i_data, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output o_det, o_det_cnt
  );
`else
  modport master (
    output i_valid, i_data, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  o_det
  );
  modport slave (
    input  i_valid, i_data, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output o_det
  );
`endif

endinterface

// File: rtl/seqdet_hist.sv
// seqdet_hist: bit history shift register plus fill counter saturating at MAX_LEN.
//   clk, reset   clock, synchronous active-high reset
//   clear_i      clear history and fill (takes priority over advance_i)
//   advance_i    shift bit_i in and bump the fill count
//   restart_i    with advance_i: shift, but restart the fill count at 0
//   bit_i        incoming serial bit
//   new_hist_o   post-shift history {hist, bit_i} seen by the comparator
//   fill_o       accepted bits since last clear/restart (pre-shift)
module seqdet_hist
  import seqdet_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = seqdet_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               advance_i,
  input  logic               restart_i,
  input  logic               bit_i,
  output logic [MAX_LEN-1:0] new_hist_o,
  output logic [LEN_W-1:0]   fill_o
);

  // The oldest history bit falls off on every shift and is never compared,
  // so only MAX_LEN-1 bits are stored; the post-shift view is rebuilt here.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  assign new_hist_o = {hist_q, bit_i};
  assign fill_o     = fill_q;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (advance_i) begin
      hist_d = new_hist_o[MAX_LEN-2:0];
      if (restart_i) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seqdet_prog.sv
// seqdet_prog: runtime-programmable serial sequence detector, registered detect.
//   clk, reset   clock, synchronous active-high reset (priority over all else)
//   bus          seqdet_prog_if.slave: i_valid/i_data stream, cfg_load with
//                cfg_pattern/cfg_len/cfg_overlap, o_det pulse, o_det_cnt
// Build option SEQDET_CNT_EN adds the saturating detect counter o_det_cnt.
module seqdet_prog
  import seqdet_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8
`ifdef SEQDET_CNT_EN
  ,
  parameter int unsigned CNT_W   = 8
`endif
) (
  input  logic          clk,
  input  logic          reset,
  seqdet_prog_if.slave  bus
);

  localparam int unsigned LEN_W = seqdet_len_w(MAX_LEN);

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    seqdet_mode_e       mode;
  } cfg_t;

  cfg_t               cfg_q, cfg_d;
  logic               det_q, det_d;
  logic               advance, match, restart;
  logic [MAX_LEN-1:0] new_hist, mask;
  logic [LEN_W-1:0]   fill;

  // A bit arriving with cfg_load is dropped.
  assign advance = bus.i_valid & ~bus.cfg_load;

  seqdet_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (bus.cfg_load),
    .advance_i  (advance),
    .restart_i  (restart),
    .bit_i      (bus.i_data),
    .new_hist_o (new_hist),
    .fill_o     (fill)
  );

  always_comb begin
    cfg_d = cfg_q;
    if (bus.cfg_load) begin
      cfg_d.pattern = bus.cfg_pattern;
      cfg_d.len     = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
      cfg_d.mode    = bus.cfg_overlap ? SEQ_OVL : SEQ_NONOVL;
    end
  end

  // Low len bits set; len == MAX_LEN shifts everything out giving all ones.
  assign mask = ~({MAX_LEN{1'b1}} << cfg_q.len);

  // fill counts bits before this one, so fill >= len-1 means len bits present.
  assign match   = (cfg_q.len != '0) &&
                   (fill >= cfg_q.len - LEN_W'(1)) &&
                   ((new_hist & mask) == (cfg_q.pattern & mask));
  assign det_d   = advance & match;
  assign restart = det_d & (cfg_q.mode == SEQ_NONOVL);

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '{pattern: '0, len: '0, mode: SEQ_OVL};
      det_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      det_q <= det_d;
    end
  end

  assign bus.o_det = det_q;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (det_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_det_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seqdet_prog.sv
// tb_seqdet_prog: directed vector table plus hand-written corner sequences
// for seqdet_prog (MAX_LEN = 8, counter width 2 when SEQDET_CNT_EN is set).
module tb_seqdet_prog;
  import seqdet_pkg::*;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = seqdet_len_w(MAX_LEN);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seqdet_prog_if #(
    .MAX_LEN (MAX_LEN)
`ifdef SEQDET_CNT_EN
    ,
    .CNT_W   (2)
`endif
  ) bus ();

  seqdet_prog #(
    .MAX_LEN (MAX_LEN)
`ifdef SEQDET_CNT_EN
    ,
    .CNT_W   (2)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic             rst;
    logic             load;
    logic             valid;
    logic             data;
    logic [7:0]       pat;
    logic [LEN_W-1:0] len;
    logic             ovl;
    logic             det;
    logic [1:0]       cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic R(input logic [1:0] c);
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b1, 1'b0, c});
  endtask

  task automatic L(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic o,
                   input logic [1:0] c);
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, p, l, o, 1'b0, c});
  endtask

  task automatic B(input logic v, input logic d, input logic e, input logic [1:0] c);
    vecs.push_back('{1'b0, 1'b0, v, d, 8'h00, '0, 1'b0, e, c});
  endtask

  task automatic drive(input vec_t x);
    reset           = x.rst;
    bus.cfg_load    = x.load;
    bus.i_valid     = x.valid;
    bus.i_data      = x.data;
    bus.cfg_pattern = x.pat;
    bus.cfg_len     = x.len;
    bus.cfg_overlap = x.ovl;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int idx, input logic edet, input logic [1:0] ecnt);
    n_vec++;
    if (bus.o_det !== edet) begin
      n_err++;
      $display("FAIL o_det vec %0d: got %b expected %b", idx, bus.o_det, edet);
    end
`ifdef SEQDET_CNT_EN
    n_vec++;
    if (bus.o_det_cnt !== ecnt) begin
      n_err++;
      $display("FAIL o_det_cnt vec %0d: got %0d expected %0d", idx, bus.o_det_cnt, ecnt);
    end
`else
    if (ecnt === 2'bxx) $display("unexpected unknown count expectation");
`endif
  endtask

  task automatic step(input int idx, input logic rst, input logic load, input logic v,
                      input logic d, input logic [7:0] p, input logic [LEN_W-1:0] l,
                      input logic o, input logic edet, input logic [1:0] ecnt);
    drive('{rst, load, v, d, p, l, o, 1'b0, 2'd0});
    check(idx, edet, ecnt);
  endtask

  initial begin
    reset = 1'b1;
    bus.cfg_load = 1'b0; bus.i_valid = 1'b0; bus.i_data = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b1;

    // overlap, 1101101 -> detects after bits 4 and 7
    R(0); L(8'h0D, 4, 1, 0);
    B(1,1,0,0); B(1,1,0,0); B(1,0,0,0); B(1,1,1,1);
    B(1,1,0,1); B(1,0,0,1); B(1,1,1,2); B(0,0,0,2);
    // non-overlap, 1101101 then 1101
    R(0); L(8'h0D, 4, 0, 0);
    B(1,1,0,0); B(1,1,0,0); B(1,0,0,0); B(1,1,1,1);
    B(1,1,0,1); B(1,0,0,1); B(1,1,0,1);
    B(1,1,0,1); B(1,1,0,1); B(1,0,0,1); B(1,1,1,2);
    // valid gaps with tempting data
    R(0); L(8'h0D, 4, 1, 0);
    B(1,1,0,0); B(1,1,0,0); B(1,0,0,0);
    B(0,1,0,0); B(0,0,0,0); B(0,1,0,0);
    B(1,1,1,1); B(0,0,0,1);
    // reset mid-sequence clears partial match, config and count
    B(1,1,0,1); B(1,1,0,1); B(1,0,0,1);
    R(0); B(1,1,0,0);
    L(8'h0D, 4, 1, 0);
    B(1,1,0,0); B(1,1,0,0); B(1,0,0,0); B(1,1,1,1);
    // mid-stream reload, len 9 clamps to 8, bit on load cycle dropped
    B(1,1,0,1); B(1,1,0,1); B(1,0,0,1);
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd9, 1'b1, 1'b0, 2'd1});
    B(1,1,0,1); B(1,0,0,1); B(1,1,0,1); B(1,0,0,1);
    B(1,0,0,1); B(1,1,0,1); B(1,0,0,1); B(1,1,1,2);
    // len 1, five ones, counter saturates at 3
    R(0); L(8'h01, 1, 1, 0);
    B(1,1,1,1); B(1,1,1,2); B(1,1,1,3); B(1,1,1,3); B(1,1,1,3);
    B(1,0,0,3); B(0,1,0,3);
    // len 0 disables detection
    L(8'hFF, 0, 1, 3); B(1,1,0,3); B(1,1,0,3);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check(i, vecs[i].det, vecs[i].cnt);
    end

    // reset wins over a simultaneous cfg_load and i_valid
    step(100, 1,0,0,0, 8'h00, 0, 1, 0, 0);
    step(101, 0,1,0,0, 8'h0D, 4, 1, 0, 0);
    step(102, 0,0,1,1, 8'h00, 0, 0, 0, 0);
    step(103, 0,0,1,1, 8'h00, 0, 0, 0, 0);
    step(104, 0,0,1,0, 8'h00, 0, 0, 0, 0);
    step(105, 1,1,1,1, 8'h01, 1, 0, 0, 0);
    step(106, 0,0,1,1, 8'h00, 0, 0, 0, 0);
    // len 1 non-overlap, cfg_load drops the bit and forces o_det low
    step(107, 0,1,0,0, 8'h01, 1, 0, 0, 0);
    step(108, 0,0,1,1, 8'h00, 0, 0, 1, 1);
    step(109, 0,1,1,1, 8'h01, 1, 0, 0, 1);
    step(110, 0,0,1,1, 8'h00, 0, 0, 1, 2);
    step(111, 0,0,1,0, 8'h00, 0, 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
